clb_config_loader: RTL and testbench

Configuration sequencer for a column of CLB tiles. It accepts bitstream words from a host over a valid/ready handshake and serialises them into the tile shift chain: slice, north CB, switch box, east CB, then on to the next tile south. Once exactly `CHAIN_LEN` bits have been shifted, it pulses the chain-wide set strobe so every tile commits its shadow configuration at once. It sits at the north edge of a tile column and drives the column's `shift_in_from_north`, `set_in_from_north` and `cen`.

---
 rtl/clb_config_loader.sv | 133 +++++++++++++
 tb/tb_clb_config_loader.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clb_config_loader.sv
// Column configuration sequencer: takes host words over valid/ready, shifts them
// LSB-first into the CLB tile chain, then strobes set so every tile commits together.
module clb_config_loader #(
  parameter int CHAIN_LEN  = 1024,
  parameter int WORD_W     = 32,
  parameter int SET_CYCLES = 1,
  localparam int BL_W      = $clog2(CHAIN_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              cen,
  output logic              shift_out,
  output logic              set_out,
  output logic              busy,
  output logic              done,
  output logic [BL_W-1:0]   bits_left
);

  localparam int WC_W = $clog2(WORD_W + 1);
  localparam int SC_W = $clog2(SET_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SHIFT,
    S_SET,
    S_DONE
  } state_t;

  state_t            state;
  logic [WORD_W-1:0] shreg;
  logic [WC_W-1:0]   word_cnt;
  logic [SC_W-1:0]   set_cnt;
  logic [31:0]       bits_left_ext;
  logic [31:0]       word_take;

  // The last word of the chain may be partial: only min(WORD_W, bits_left) bits go out.
  always_comb begin
    bits_left_ext = 32'(bits_left);
    word_take     = (bits_left_ext >= 32'(WORD_W)) ? 32'(WORD_W) : bits_left_ext;
  end

  // shift_out is presented one cycle ahead of the chain edge that captures it, so
  // the current bit lives in shift_out and shreg holds only the bits still to come.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      shreg     <= '0;
      word_cnt  <= '0;
      set_cnt   <= '0;
      bits_left <= '0;
      cfg_ready <= 1'b0;
      cen       <= 1'b0;
      shift_out <= 1'b0;
      set_out   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_FETCH;
            bits_left <= BL_W'(CHAIN_LEN);
            busy      <= 1'b1;
            cfg_ready <= 1'b1;
          end
        end

        S_FETCH: begin
          if (cfg_valid && cfg_ready) begin
            state     <= S_SHIFT;
            shreg     <= cfg_data >> 1;
            shift_out <= cfg_data[0];
            word_cnt  <= WC_W'(word_take);
            cen       <= 1'b1;
            cfg_ready <= 1'b0;
          end
        end

        S_SHIFT: begin
          bits_left <= bits_left - BL_W'(1);
          word_cnt  <= word_cnt - WC_W'(1);
          if (word_cnt == WC_W'(1)) begin
            cen       <= 1'b0;
            shift_out <= 1'b0;
            shreg     <= '0;
            if (bits_left == BL_W'(1)) begin
              state   <= S_SET;
              set_out <= 1'b1;
              set_cnt <= SC_W'(SET_CYCLES);
            end else begin
              state     <= S_FETCH;
              cfg_ready <= 1'b1;
            end
          end else begin
            shift_out <= shreg[0];
            shreg     <= shreg >> 1;
          end
        end

        S_SET: begin
          set_cnt <= set_cnt - SC_W'(1);
          if (set_cnt == SC_W'(1)) begin
            state   <= S_DONE;
            set_out <= 1'b0;
            done    <= 1'b1;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end

        default: begin
          state     <= S_IDLE;
          cfg_ready <= 1'b0;
          cen       <= 1'b0;
          shift_out <= 1'b0;
          set_out   <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clb_config_loader.sv
// Bench for clb_config_loader: two configurations (40/16/1 and 32/16/3) driven from
// a vector table plus reset and idle-input sequences, checked against a bit-stream model.
module tb_clb_config_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_req = 1'b0;
  logic [15:0] cfg_data = '0;
  logic        cfg_valid = 1'b0;
  bit          sel = 1'b0;

  logic        start_a, ready_a, cen_a, so_a, set_a, busy_a, done_a;
  logic        start_b, ready_b, cen_b, so_b, set_b, busy_b, done_b;
  logic [5:0]  bl_a, bl_b;

  assign start_a = start_req && !sel;
  assign start_b = start_req && sel;

  clb_config_loader #(.CHAIN_LEN(40), .WORD_W(16), .SET_CYCLES(1)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .cfg_data(cfg_data), .cfg_valid(cfg_valid),
    .cfg_ready(ready_a), .cen(cen_a), .shift_out(so_a), .set_out(set_a),
    .busy(busy_a), .done(done_a), .bits_left(bl_a));

  clb_config_loader #(.CHAIN_LEN(32), .WORD_W(16), .SET_CYCLES(3)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .cfg_data(cfg_data), .cfg_valid(cfg_valid),
    .cfg_ready(ready_b), .cen(cen_b), .shift_out(so_b), .set_out(set_b),
    .busy(busy_b), .done(done_b), .bits_left(bl_b));

  always #5 clk = ~clk;

  logic cur_ready, cur_cen, cur_set, cur_busy, cur_done;
  assign cur_ready = sel ? ready_b : ready_a;
  assign cur_cen   = sel ? cen_b   : cen_a;
  assign cur_set   = sel ? set_b   : set_a;
  assign cur_busy  = sel ? busy_b  : busy_a;
  assign cur_done  = sel ? done_b  : done_a;

  int checks = 0;
  int errors = 0;

  task automatic check_output(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Chain stand-in: bits captured on every cen cycle of the selected loader.
  bit   obs[$];
  int   load_cen = 0;
  int   load_set = 0;
  int   cur_len  = 40;
  int   cen_seen[2] = '{0, 0};
  int   len_of[2]   = '{40, 32};

  logic       m_cen[2], m_so[2], m_set[2], m_busy[2];
  logic [5:0] m_bl[2];
  assign m_cen[0] = cen_a;  assign m_cen[1] = cen_b;
  assign m_so[0]  = so_a;   assign m_so[1]  = so_b;
  assign m_set[0] = set_a;  assign m_set[1] = set_b;
  assign m_busy[0] = busy_a; assign m_busy[1] = busy_b;
  assign m_bl[0]  = bl_a;   assign m_bl[1]  = bl_b;

  // Per-cycle invariants: exclusivity of cen/set, quiet line, bits_left = len - shifted.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      check_output("cen_and_set", longint'(m_cen[i] && m_set[i]), 0);
      check_output("shift_out_quiet", longint'(!m_cen[i] && m_so[i]), 0);
      if (m_busy[i] && !rst)
        check_output("bits_left", longint'(m_bl[i]), longint'(len_of[i] - cen_seen[i]));
      if (!m_busy[i]) cen_seen[i] = 0;
      else if (m_cen[i]) cen_seen[i]++;
    end
    if (cur_cen) begin
      obs.push_back(bit'(sel ? so_b : so_a));
      load_cen++;
    end
    if (cur_set) begin
      if (load_set == 0) check_output("commit_len", obs.size(), cur_len);
      load_set++;
    end
  end

  typedef struct {
    bit dut;
    int extra;
    int stall_after;
    int stall_len;
    bit start_in_shift;
    bit start_in_set;
    bit valid_at_start;
    bit fixed_words;
    int exp_latency;
    int exp_cen;
    int exp_set;
  } vec_t;

  vec_t vecs[5];

  task automatic apply_stimulus(input vec_t v);
    logic [15:0] words[$];
    bit          exp_bits[$];
    logic [15:0] fixed_w[3];
    logic [15:0] w;
    int need, idx, accepted, stall_cnt, cyc, first_bad;
    bit pulsed_shift, pulsed_set;
    fixed_w = '{16'hA5A5, 16'h0F0F, 16'hFF3C};
    @(negedge clk);
    sel      = v.dut;
    cur_len  = v.dut ? 32 : 40;
    need     = (cur_len + 15) / 16;
    obs.delete();
    load_cen = 0;
    load_set = 0;
    for (int k = 0; k < need + v.extra; k++) begin
      if (v.fixed_words && k < 3) w = fixed_w[k];
      else w = 16'($urandom_range(0, 65535));
      words.push_back(w);
      for (int b = 0; b < 16; b++)
        if (exp_bits.size() < cur_len) exp_bits.push_back(w[b]);
    end
    idx = 0; accepted = 0; stall_cnt = 0; pulsed_shift = 0; pulsed_set = 0;
    check_output("idle_ready", longint'(cur_ready), 0);
    check_output("idle_busy", longint'(cur_busy), 0);
    start_req = 1'b1;
    cfg_valid = v.valid_at_start;
    cfg_data  = words[0];
    cyc = 1;
    @(negedge clk);
    start_req = 1'b0;
    cyc = 2;
    while (!cur_done && cyc < 600) begin
      start_req = 1'b0;
      if (v.start_in_shift && cur_cen && load_cen >= 5 && !pulsed_shift) begin
        start_req = 1'b1; pulsed_shift = 1;
      end
      if (v.start_in_set && cur_set && !pulsed_set) begin
        start_req = 1'b1; pulsed_set = 1;
      end
      if (idx < words.size()) begin
        if (idx == v.stall_after && stall_cnt < v.stall_len && cur_ready) begin
          cfg_valid = 1'b0;
          stall_cnt++;
          check_output("stall_cen", longint'(cur_cen), 0);
        end else begin
          cfg_valid = 1'b1;
          cfg_data  = words[idx];
        end
      end else begin
        cfg_valid = 1'b0;
      end
      if (cfg_valid && cur_ready) begin
        accepted++;
        idx++;
      end
      @(negedge clk);
      cyc++;
    end
    start_req = 1'b0;
    check_output("done_timeout", longint'(cyc >= 600), 0);
    check_output("latency", cyc, v.exp_latency);
    check_output("cen_cycles", load_cen, v.exp_cen);
    check_output("set_cycles", load_set, v.exp_set);
    check_output("words_accepted", accepted, need);
    first_bad = -1;
    for (int i = 0; i < cur_len; i++)
      if (first_bad < 0 && (i >= obs.size() || obs[i] != exp_bits[i])) first_bad = i;
    check_output("stream_first_bad_bit", first_bad, -1);
    check_output("stream_len", obs.size(), cur_len);
    @(negedge clk);
    cfg_valid = 1'b0;
    check_output("busy_after_done", longint'(cur_busy), 0);
    check_output("done_one_cycle", longint'(cur_done), 0);
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_ready_a"}, longint'(ready_a), 0);
    check_output({tag, "_cen_a"}, longint'(cen_a), 0);
    check_output({tag, "_so_a"}, longint'(so_a), 0);
    check_output({tag, "_set_a"}, longint'(set_a), 0);
    check_output({tag, "_busy_a"}, longint'(busy_a), 0);
    check_output({tag, "_done_a"}, longint'(done_a), 0);
    check_output({tag, "_bl_a"}, longint'(bl_a), 0);
    check_output({tag, "_busy_b"}, longint'(busy_b), 0);
    check_output({tag, "_bl_b"}, longint'(bl_b), 0);
  endtask

  initial begin
    int guard;
    logic [5:0] bl_before;
    //           dut extra stall_af stall_len sh  set vst fixed lat cen set
    vecs[0] = '{1'b0, 0, -1, 0, 1'b0, 1'b0, 1'b0, 1'b1, 46, 40, 1};
    vecs[1] = '{1'b0, 0,  1, 5, 1'b0, 1'b0, 1'b0, 1'b1, 51, 40, 1};
    vecs[2] = '{1'b1, 1, -1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 39, 32, 3};
    vecs[3] = '{1'b0, 0, -1, 0, 1'b1, 1'b1, 1'b1, 1'b0, 46, 40, 1};
    vecs[4] = '{1'b1, 0,  0, 4, 1'b1, 1'b1, 1'b0, 1'b0, 43, 32, 3};

    #12;
    check_reset_values("reset");
    @(negedge clk);
    rst = 1'b0;

    // cfg_valid while idle must not be accepted or disturb state.
    sel = 1'b0;
    bl_before = bl_a;
    cfg_valid = 1'b1;
    cfg_data  = 16'h1234;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_output("idle_valid_ready", longint'(ready_a), 0);
      check_output("idle_valid_busy", longint'(busy_a), 0);
      check_output("idle_valid_bl", longint'(bl_a), longint'(bl_before));
    end
    cfg_valid = 1'b0;

    for (int i = 0; i < 5; i++) begin
      $display("[TB] vector %0d", i);
      apply_stimulus(vecs[i]);
    end

    // Reset after 10 shifted bits: outputs clear at once, no set, then a clean reload.
    @(negedge clk);
    sel = 1'b0;
    obs.delete();
    load_cen = 0;
    load_set = 0;
    start_req = 1'b1;
    @(negedge clk);
    start_req = 1'b0;
    cfg_valid = 1'b1;
    cfg_data  = 16'hA5A5;
    guard = 0;
    while (load_cen < 10 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check_output("reset_seq_timeout", longint'(guard >= 200), 0);
    rst = 1'b1;
    #1;
    check_reset_values("midrst");
    cfg_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check_output("set_after_reset", load_set, 0);
    check_output("busy_after_reset", longint'(busy_a), 0);
    apply_stimulus(vecs[0]);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
